// File: rtl/rtc_bus_pkg.sv
// Shared types and bus polarity constants for the RTC bus sequencer.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    A_REC,
    D_SETUP,
    D_STROBE,
    D_HOLD,
    D_REC
  } seq_state_t;

  typedef enum logic {
    PH_ADDR,
    PH_DATA
  } phase_t;

  localparam logic CS_ACTIVE = 1'b0;
  localparam logic AD_ADDR   = 1'b0;
  localparam logic AD_DATA   = 1'b1;

  // Which half of the transaction a state belongs to.
  function automatic phase_t phase_of(input seq_state_t s);
    return (s inside {D_SETUP, D_STROBE, D_HOLD, D_REC}) ? PH_DATA : PH_ADDR;
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Command/response handshake between the RTC control FSM and the sequencer.
interface rtc_bus_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rtc_bus_sequencer_refresh_timer.sv
// Periodic refresh request: free-running tick counter plus a sticky pending flag.
// Only used when RTC_SEQ_REFRESH_EN is defined.
module rtc_refresh_timer #(
  parameter int REFRESH_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic pending
);
  localparam int CW = $clog2(REFRESH_CYC);

  logic [CW-1:0] count;
  logic          tick;

  assign tick = en && (count == CW'(REFRESH_CYC - 1));

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process evaluation order.
  // Counter runs only while enabled and restarts from zero after each tick.
  always_ff @(posedge clk) begin
    if (!reset)            count <= '0;
    else if (!en || tick)  count <= '0;
    else                   count <= count + 1'b1;
  end

  // Pending is sticky; ticks while already pending collapse into one request.
  always_ff @(posedge clk) begin
    if (!reset)    pending <= 1'b0;
    else if (clr)  pending <= 1'b0;
    else if (tick) pending <= 1'b1;
  end
endmodule

// File: rtl/rtc_bus_sequencer.sv
// Phase generator for the RTC multiplexed address/data bus. Serves single
// read/write commands and, with RTC_SEQ_REFRESH_EN defined, periodic burst reads
// of BASE_ADDR..BASE_ADDR+N_REGS-1 into an atomically updated shadow bank.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int         PHASE_CYC   = 4,
  parameter int         GAP_CYC     = 2,
  parameter int         N_REGS      = 7,
  parameter logic [7:0] BASE_ADDR   = 8'h21,
  parameter int         REFRESH_CYC = 50000
) (
  input  logic                clk,
  input  logic                reset,
  rtc_bus_sequencer_if.slave  cmd,
  input  logic                refresh_en,
  output logic [8*N_REGS-1:0] shadow,
  output logic                shadow_update,
  output logic                busy,
  inout  wire  [7:0]          dato,
  output logic                a_d,
  output logic                cs,
  output logic                rd,
  output logic                wr
);

  seq_state_t  state, next_state;
  logic [15:0] cnt;
  logic        strobe_last, gap_last, burst_last, done;
  logic        accept, burst_start, pending;
  logic        write_q, burst_q, cur_write;
  logic [7:0]  addr_q, wdata_q, cur_addr, dout;
  logic [3:0]  idx;
  logic        drive_en;

  assign strobe_last = (cnt == 16'(PHASE_CYC - 1));
  assign gap_last    = (cnt == 16'(GAP_CYC - 1));
  assign burst_last  = (idx == 4'(N_REGS - 1));
  assign done        = (state == D_REC) && gap_last;

  // Ready is suppressed while reset is held so nothing is accepted on that edge.
  assign cmd.cmd_ready = reset && (state == IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign burst_start   = cmd.cmd_ready && !cmd.cmd_valid && pending;

  assign cur_write = !burst_q && write_q;
  assign cur_addr  = burst_q ? 8'(BASE_ADDR + {4'd0, idx}) : addr_q;
  assign busy      = (state != IDLE);
  assign dato      = drive_en ? dout : 8'bz;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: fixed phase sequence, bursts loop back to A_SETUP per register.
  always_comb begin
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    next_state = state;
    case (state)
      IDLE:     if (accept || burst_start) next_state = A_SETUP;
      A_SETUP:  next_state = A_STROBE;
      A_STROBE: if (strobe_last) next_state = A_HOLD;
      A_HOLD:   next_state = A_REC;
      A_REC:    if (gap_last) next_state = D_SETUP;
      D_SETUP:  next_state = D_STROBE;
      D_STROBE: if (strobe_last) next_state = D_HOLD;
      D_HOLD:   next_state = D_REC;
      D_REC:    if (gap_last) next_state = (burst_q && !burst_last) ? A_SETUP : IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Bus pin decode from the current state.
  always_comb begin
    cs       = ~CS_ACTIVE;
    rd       = 1'b1;
    wr       = 1'b1;
    a_d      = (phase_of(state) == PH_DATA) ? AD_DATA : AD_ADDR;
    drive_en = 1'b0;
    dout     = (phase_of(state) == PH_ADDR) ? cur_addr : wdata_q;
    case (state)
      A_SETUP, A_HOLD: begin cs = CS_ACTIVE; drive_en = 1'b1; end
      A_STROBE:        begin cs = CS_ACTIVE; drive_en = 1'b1; wr = 1'b0; end
      D_SETUP, D_HOLD: begin cs = CS_ACTIVE; drive_en = cur_write; end
      D_STROBE: begin
        cs       = CS_ACTIVE;
        drive_en = cur_write;
        wr       = !cur_write;
        rd       = cur_write;
      end
      default: ;
    endcase
  end

  // Phase cycle counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (!reset)                   cnt <= '0;
    else if (state != next_state) cnt <= '0;
    else                          cnt <= cnt + 16'd1;
  end

  // Command capture, burst index and single-command response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      burst_q       <= 1'b0;
      idx           <= '0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_rdata <= '0;
    end else begin
      cmd.rsp_valid <= done && !burst_q;
      if (accept) begin
        write_q <= cmd.cmd_write;
        addr_q  <= cmd.cmd_addr;
        wdata_q <= cmd.cmd_wdata;
        burst_q <= 1'b0;
        idx     <= '0;
      end else if (burst_start) begin
        burst_q <= 1'b1;
        idx     <= '0;
      end else if (done && burst_q && !burst_last) begin
        idx <= idx + 4'd1;
      end
      if (state == D_STROBE && strobe_last && !burst_q && !write_q)
        cmd.rsp_rdata <= dato;
    end
  end

`ifdef RTC_SEQ_REFRESH_EN
  logic [8*N_REGS-1:0] stage;

  rtc_refresh_timer #(.REFRESH_CYC(REFRESH_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (refresh_en),
    .clr     (burst_start),
    .pending (pending)
  );

  // NOTE: the staging bank has no reset; every byte is rewritten by a burst before
  // it can be committed, and an interrupted burst is simply never committed.
  // Burst read data lands in the staging bank on the last strobe cycle.
  always_ff @(posedge clk) begin
    if (state == D_STROBE && strobe_last && burst_q)
      stage[int'(idx)*8 +: 8] <= dato;
  end

  // Whole bank becomes visible at once when the final register completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow        <= '0;
      shadow_update <= 1'b0;
    end else begin
      shadow_update <= done && burst_q && burst_last;
      if (done && burst_q && burst_last) shadow <= stage;
    end
  end
`else
  logic unused_refresh;
  assign unused_refresh = refresh_en ^ (REFRESH_CYC == 0);
  assign pending        = 1'b0;
  assign shadow         = '0;
  assign shadow_update  = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: bus model on dato, response and
// shadow scoreboards, one task per scenario.
module tb_rtc_bus_sequencer;
  localparam int         N_REGS = 7;
  localparam logic [7:0] BASE   = 8'h21;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic refresh_en = 1'b0;
  logic [8*N_REGS-1:0] shadow;
  logic shadow_update, busy, a_d, cs, rd, wr;
  wire  [7:0] dato;

  always #5 clk = ~clk;

  rtc_bus_sequencer_if bus_if ();

  rtc_bus_sequencer #(.REFRESH_CYC(100)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .cmd           (bus_if),
    .refresh_en    (refresh_en),
    .shadow        (shadow),
    .shadow_update (shadow_update),
    .busy          (busy),
    .dato          (dato),
    .a_d           (a_d),
    .cs            (cs),
    .rd            (rd),
    .wr            (wr)
  );

  // RTC chip model: latches the address, answers reads with 0x59 or addr+1.
  logic       m_inc = 1'b0;
  logic [7:0] m_addr = 8'h00;
  always @(posedge clk) if (!cs && !wr && !a_d) m_addr <= dato;
  assign dato = (!cs && !rd) ? (m_inc ? m_addr + 8'd1 : 8'h59) : 8'bz;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       is_read;
    logic [7:0] rdata;
  } rsp_t;
  rsp_t                rsp_q[$];
  logic [8*N_REGS-1:0] shadow_q[$];
  rsp_t                exp_rsp;
  logic [8*N_REGS-1:0] exp_shadow;

  // Scoreboard: every response / shadow update must match a queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (bus_if.rsp_valid) begin
        checks++;
        if (rsp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: got rsp_valid rdata=%h, required no response", bus_if.rsp_rdata);
        end else begin
          exp_rsp = rsp_q.pop_front();
          if (exp_rsp.is_read && bus_if.rsp_rdata !== exp_rsp.rdata) begin
            failures++;
            $display("FAIL rsp_rdata: got %h, required %h", bus_if.rsp_rdata, exp_rsp.rdata);
          end
        end
      end
      if (shadow_update) begin
        checks++;
        if (shadow_q.size() == 0) begin
          failures++;
          $display("FAIL shadow_unexpected: got shadow_update shadow=%h, required none", shadow);
        end else begin
          exp_shadow = shadow_q.pop_front();
          if (shadow !== exp_shadow) begin
            failures++;
            $display("FAIL shadow_value: got %h, required %h", shadow, exp_shadow);
          end
        end
      end
    end
  end

  task automatic push_rsp(input logic is_read, input logic [7:0] rdata);
    rsp_t r;
    r.is_read = is_read;
    r.rdata   = rdata;
    rsp_q.push_back(r);
  endtask

  // Called after a negedge: presents a command for the current cycle.
  task automatic drive_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = w;
    bus_if.cmd_addr  = a;
    bus_if.cmd_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_if.cmd_ready, bus_if.rsp_valid, bus_if.rsp_rdata, shadow_update, busy, cs, rd, wr, a_d}
        !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b rdata=%h upd=%b busy=%b cs=%b rd=%b wr=%b a_d=%b, required 0 0 00 0 0 1 1 1 0",
               bus_if.cmd_ready, bus_if.rsp_valid, bus_if.rsp_rdata, shadow_update, busy, cs, rd, wr, a_d);
    end
    checks++;
    if (shadow !== '0) begin
      failures++;
      $display("FAIL reset_shadow: got %h, required 0", shadow);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b busy=%b, required ready=1 busy=0", bus_if.cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    drive_cmd(1'b1, 8'h22, 8'h45);
    push_rsp(1'b0, 8'h00);
    checks++;
    if (bus_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL write_accept: got cmd_ready=%b, required 1", bus_if.cmd_ready);
    end
    @(posedge clk);
    #1 bus_if.cmd_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 5) begin
        checks++;
        if ({dato, wr, a_d, cs} !== {8'h22, 1'b0, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL write_addr_phase c%0d: got dato=%h wr=%b a_d=%b cs=%b, required 22 0 0 0", k, dato, wr, a_d, cs);
        end
      end
      if (k >= 10 && k <= 13) begin
        checks++;
        if ({dato, wr, rd, a_d, cs} !== {8'h45, 1'b0, 1'b1, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL write_data_phase c%0d: got dato=%h wr=%b rd=%b a_d=%b cs=%b, required 45 0 1 1 0", k, dato, wr, rd, a_d, cs);
        end
      end
      if (k == 7) begin
        checks++;
        if ({cs, wr, rd} !== 3'b111) begin
          failures++;
          $display("FAIL write_recover c%0d: got cs/wr/rd=%b, required 111", k, {cs, wr, rd});
        end
      end
      checks++;
      if (bus_if.rsp_valid !== (k == 17)) begin
        failures++;
        $display("FAIL write_rsp_timing c%0d: got rsp_valid=%b, required %b", k, bus_if.rsp_valid, k == 17);
      end
    end
  endtask

  task automatic test_read();
    m_inc = 1'b0;
    @(negedge clk);
    drive_cmd(1'b0, 8'h23, 8'h00);
    push_rsp(1'b1, 8'h59);
    @(posedge clk);
    #1 bus_if.cmd_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 5) begin
        checks++;
        if ({dato, wr, a_d} !== {8'h23, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL read_addr_phase c%0d: got dato=%h wr=%b a_d=%b, required 23 0 0", k, dato, wr, a_d);
        end
      end
      if (k >= 10 && k <= 13) begin
        checks++;
        if ({dato, rd, wr, a_d, cs} !== {8'h59, 1'b0, 1'b1, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL read_data_phase c%0d: got dato=%h rd=%b wr=%b a_d=%b cs=%b, required 59 0 1 1 0", k, dato, rd, wr, a_d, cs);
        end
      end
      checks++;
      if (bus_if.rsp_valid !== (k == 17)) begin
        failures++;
        $display("FAIL read_rsp_timing c%0d: got rsp_valid=%b, required %b", k, bus_if.rsp_valid, k == 17);
      end
    end
  endtask

  task automatic test_back_to_back();
    m_inc = 1'b1;
    @(negedge clk);
    drive_cmd(1'b1, 8'h30, 8'hA5);
    push_rsp(1'b0, 8'h00);
    push_rsp(1'b1, 8'h32);
    @(posedge clk);
    #1 drive_cmd(1'b0, 8'h31, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      checks++;
      if (bus_if.cmd_ready !== (k == 17) || bus_if.rsp_valid !== (k == 17)) begin
        failures++;
        $display("FAIL b2b_first c%0d: got ready=%b rsp_valid=%b, required %b %b", k, bus_if.cmd_ready, bus_if.rsp_valid, k == 17, k == 17);
      end
    end
    @(posedge clk);
    #1 bus_if.cmd_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      checks++;
      if (bus_if.rsp_valid !== (k == 17)) begin
        failures++;
        $display("FAIL b2b_second c%0d: got rsp_valid=%b, required %b", k, bus_if.rsp_valid, k == 17);
      end
    end
  endtask

`ifdef RTC_SEQ_REFRESH_EN
  task automatic test_refresh_burst();
    logic [8*N_REGS-1:0] exp;
    logic found, early_ready;
    for (int i = 0; i < N_REGS; i++) exp[i*8 +: 8] = BASE + 8'(i) + 8'd1;
    // Tick lands during the first burst, so a second burst follows the command.
    shadow_q.push_back(exp);
    shadow_q.push_back(exp);
    push_rsp(1'b1, 8'h41);
    m_inc = 1'b1;
    @(negedge clk);
    refresh_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      found = busy;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL burst_start: got busy=0 after 200 cycles, required burst");
    end
    repeat (3) @(negedge clk);
    drive_cmd(1'b0, 8'h40, 8'h00);
    found = 1'b0;
    early_ready = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (shadow_update) found = 1'b1;
      else if (bus_if.cmd_ready) early_ready = 1'b1;
    end
    checks++;
    if (!found || early_ready || bus_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL burst_blocks_cmd: got update=%b early_ready=%b ready_at_update=%b, required 1 0 1", found, early_ready, bus_if.cmd_ready);
    end
    @(posedge clk);
    #1 bus_if.cmd_valid = 1'b0;
    refresh_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, cs, a_d} !== 3'b100) begin
      failures++;
      $display("FAIL cmd_after_burst: got busy/cs/a_d=%b, required 100", {busy, cs, a_d});
    end
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      found = (shadow_q.size() == 0);
    end
    checks++;
    if (!found || rsp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_kept: got %0d shadow and %0d rsp outstanding, required 0 0", shadow_q.size(), rsp_q.size());
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL burst_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic found, seen_busy;
    @(negedge clk);
    refresh_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      found = (!cs && !rd && a_d);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_burst_reach: got no D_STROBE within 300 cycles, required one");
    end
    reset = 1'b0;
    refresh_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({cs, rd, wr, busy, shadow_update, bus_if.cmd_ready} !== 6'b111000 || shadow !== '0) begin
      failures++;
      $display("FAIL mid_burst_reset: got cs/rd/wr/busy/upd/rdy=%b shadow=%h, required 111000 0",
               {cs, rd, wr, busy, shadow_update, bus_if.cmd_ready}, shadow);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    seen_busy = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    checks++;
    if (seen_busy || shadow !== '0) begin
      failures++;
      $display("FAIL mid_burst_discard: got busy_seen=%b shadow=%h, required 0 0", seen_busy, shadow);
    end
  endtask
`else
  task automatic test_no_refresh();
    logic seen_busy, seen_upd;
    seen_busy = 1'b0;
    seen_upd  = 1'b0;
    @(negedge clk);
    refresh_en = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      if (shadow_update) seen_upd = 1'b1;
    end
    refresh_en = 1'b0;
    checks++;
    if (seen_busy || seen_upd || shadow !== '0) begin
      failures++;
      $display("FAIL no_refresh: got busy_seen=%b upd_seen=%b shadow=%h, required 0 0 0", seen_busy, seen_upd, shadow);
    end
  endtask
`endif

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_write = 1'b0;
    bus_if.cmd_addr  = 8'h00;
    bus_if.cmd_wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
`ifdef RTC_SEQ_REFRESH_EN
    test_refresh_burst();
    test_reset_mid_burst();
`else
    test_no_refresh();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_q.size() != 0 || shadow_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d rsp and %0d shadow outstanding, required 0 0", rsp_q.size(), shadow_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Parametrised transaction engine for the RTC's multiplexed address/data bus (`a_d`, `cs`, `rd`, `wr`, `dato`). It replaces hard-coded read/write timing with a configurable phase generator. It serves single read/write commands from the control FSM and autonomously burst-reads a block of RTC registers into an atomically updated shadow bank. It sits between the RTC control logic (time/date/timer editing) and the chip pins.

## Interface
- `PHASE_CYC`, 4: cycles the `rd`/`wr` strobe is held low per phase (≥1).
- `GAP_CYC`, 2: idle recovery cycles after each phase (≥1).
- `N_REGS`, 7: registers per refresh burst (1..16).
- `BASE_ADDR`, 8'h21: first address of the refresh burst.
- `REFRESH_CYC`, 50000: clock cycles between refresh ticks (≥2).

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  engine accepts command this cycle.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  8  RTC register address.
- `cmd_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle pulse: command finished.
- `rsp_rdata`  out  8  read data; valid with `rsp_valid` on reads, held otherwise.
- `refresh_en`  in  1  enables periodic burst refresh.
- `shadow`  out  8*N_REGS  shadow bank; byte i = register BASE_ADDR+i.
- `shadow_update`  out  1  one-cycle pulse when the bank is updated.
- `busy`  out  1  state ≠ IDLE.
- `dato`  inout  8  multiplexed bus; driven only when the engine owns it, else Z.
- `a_d`, `cs`, `rd`, `wr`  out  1 each  bus controls; `cs`/`rd`/`wr` active-low; `a_d` 0 = address phase, 1 = data phase.

## Operation
- Transaction = address phase, then data phase. Each phase is SETUP (1 cycle: `cs`=0, `a_d` set, bus driven if writing), STROBE (`PHASE_CYC` cycles, strobe low), HOLD (1 cycle: strobe high, `cs`=0, bus still driven), RECOVER (`GAP_CYC` cycles: `cs`=`rd`=`wr`=1, `dato`=Z).
- Address phase: always drives `cmd_addr` with the `wr` strobe. Data phase, write: drives `cmd_wdata` with `wr`. Data phase, read: `dato`=Z with `rd`; the bus is sampled on the last STROBE cycle.
- FSM states: IDLE, A_SETUP, A_STROBE, A_HOLD, A_REC, D_SETUP, D_STROBE, D_HOLD, D_REC.
  - D_REC exits to IDLE, or to A_SETUP for the next burst register.
- Arbitration in IDLE: a valid command wins over a pending refresh. A burst is never interrupted, and `cmd_ready`=0 for its whole duration.
- Refresh timer counts while `refresh_en`=1 and sets `refresh_pending` on reaching `REFRESH_CYC`-1, then wraps to 0. A tick while already pending is dropped (no accumulation). Clearing `refresh_en` zeroes the counter but keeps any pending request.
- Burst: reads addresses `BASE_ADDR`..`BASE_ADDR`+`N_REGS`-1 (8-bit wrap) into a staging bank. On the final D_REC→IDLE transition, the staging bank is copied into `shadow` and `shadow_update` pulses. Partial data is never visible. Bursts do not pulse `rsp_valid`.

## Timing
- Reset values: `cmd_ready`=0 during reset, 1 on the first cycle after; `rsp_valid`=0, `rsp_rdata`=0, `shadow`=0, `shadow_update`=0, `busy`=0, `cs`=`rd`=`wr`=1, `a_d`=0, `dato`=Z; timer=0, pending=0.
- Phase length P = `PHASE_CYC`+2+`GAP_CYC`; transaction length = 2P (16 cycles at defaults).
- Command accepted at cycle 0 (`cmd_valid`&`cmd_ready`): A_SETUP at cycle 1; `rsp_valid` on cycle 2P+1, which is the first IDLE cycle, with `cmd_ready`=1 in that same cycle (back-to-back allowed).
- Burst length = N_REGS·2P cycles; `shadow_update` fires on the first IDLE cycle after it.
- Reset asserted mid-transaction: next edge forces the reset values above; the staging bank is discarded and the command is lost with no `rsp_valid`.

## Configuration
- `RTC_SEQ_REFRESH_EN` defined: refresh timer, staging bank and burst logic are present, as described above.
- Not defined: `refresh_en` ignored, `shadow`=0 and `shadow_update`=0 constantly, and the FSM serves commands only.

## Structure
- Package `rtc_bus_pkg`: FSM state enum, phase-select enum, bus polarity constants (`CS_ACTIVE`=0, `AD_ADDR`=0, `AD_DATA`=1).
- Sub-module `rtc_refresh_timer`: counter, enable handling and pending latch with clear input; compiled only under `RTC_SEQ_REFRESH_EN`.

## Test plan
- Write addr 8'h22, data 8'h45, defaults → `dato`=8'h22 with `wr`=0, `a_d`=0 for cycles 2–5; `dato`=8'h45 with `a_d`=1 for cycles 10–13; `rsp_valid` at cycle 17.
- Read addr 8'h23 with bus model returning 8'h59 during `rd`=0 → `dato` Z in the data phase, `rsp_rdata`=8'h59 with `rsp_valid` at cycle 17.
- `REFRESH_CYC`=100, `refresh_en`=1, model returns addr+1 → after burst, `shadow` byte i = BASE_ADDR+i+1, one `shadow_update`, no `rsp_valid`.
- Command raised 3 cycles into a burst → `cmd_ready`=0 until the burst ends; command starts the cycle after `shadow_update`.
- Reset pulled low in D_STROBE of a burst → next cycle `cs`=`rd`=`wr`=1, `dato`=Z, `shadow`=0, no `shadow_update`.
- Macro undefined, `refresh_en`=1 for 500 cycles → `busy` stays 0 and `shadow_update` never pulses.
